uart_int_ctrl: RTL

// Interrupt scheduler for the UART APB register block. Latches the line-status, RX-data,

---
 rtl/uart_int_ctrl_if.sv | 43 ++++
 rtl/uart_int_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_int_ctrl_if.sv
// ----------------------------------------------------------------------
// uart_int_ctrl_if : register-block <-> interrupt scheduler signal bundle
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface uart_int_ctrl_if;
  logic       erbi;
  logic       etbei;
  logic       elsi;
  logic       fifoen;
  logic       oe;
  logic       pe;
  logic       fe;
  logic       bi;
  logic       dr;
  logic       rx_lvl_hit;
  logic       rx_fifo_empty;
  logic       rx_char;
  logic       char_tick;
  logic       thre;
  logic       thr_wr;
  logic       rbr_rd;
  logic       lsr_rd;
  logic       iir_rd;
  logic [2:0] intid;
  logic       ipend_n;
  logic       uart_intpt;

  modport master (
    output erbi, etbei, elsi, fifoen, oe, pe, fe, bi, dr, rx_lvl_hit, rx_fifo_empty,
           rx_char, char_tick, thre, thr_wr, rbr_rd, lsr_rd, iir_rd,
    input  intid, ipend_n, uart_intpt
  );

  modport slave (
    input  erbi, etbei, elsi, fifoen, oe, pe, fe, bi, dr, rx_lvl_hit, rx_fifo_empty,
           rx_char, char_tick, thre, thr_wr, rbr_rd, lsr_rd, iir_rd,
    output intid, ipend_n, uart_intpt
  );
endinterface

`default_nettype wire

// File: rtl/uart_int_ctrl.sv
// ----------------------------------------------------------------------
// uart_int_ctrl : UART interrupt latch, mask and fixed-priority encoder
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module uart_int_ctrl #(
  parameter int TIMEOUT_CHARS = 4,
  parameter int CNT_W         = 3
) (
  input  logic               pclk,
  input  logic               presetn,
  uart_int_ctrl_if.slave     bus
);

  localparam logic [CNT_W-1:0] C_TMO_MAX = CNT_W'(TIMEOUT_CHARS);
  localparam logic [2:0]       C_ID_LS   = 3'b011;
  localparam logic [2:0]       C_ID_RDA  = 3'b010;
  localparam logic [2:0]       C_ID_TMO  = 3'b110;
  localparam logic [2:0]       C_ID_THR  = 3'b001;
  localparam logic [2:0]       C_ID_NONE = 3'b000;

  logic             ls_pend_q,   ls_pend_d;
  logic             thre_pend_q, thre_pend_d;
  logic             thre_q,      thre_d;
  logic             etbei_q,     etbei_d;
  logic [CNT_W-1:0] tmo_cnt_q,   tmo_cnt_d;
  logic             tmo_pend_q,  tmo_pend_d;
  logic [2:0]       intid_q,     intid_d;
  logic             ipend_n_q,   ipend_n_d;

  logic w_rda, w_ls_en, w_rda_en, w_tmo_en, w_thr_en;
  logic w_thre_set, w_thre_clr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ls_pend_q   <= 1'b0;
      thre_pend_q <= 1'b0;
      thre_q      <= 1'b1;
      etbei_q     <= 1'b0;
      tmo_cnt_q   <= '0;
      tmo_pend_q  <= 1'b0;
      intid_q     <= C_ID_NONE;
      ipend_n_q   <= 1'b1;
    end else begin
      ls_pend_q   <= ls_pend_d;
      thre_pend_q <= thre_pend_d;
      thre_q      <= thre_d;
      etbei_q     <= etbei_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pend_q  <= tmo_pend_d;
      intid_q     <= intid_d;
      ipend_n_q   <= ipend_n_d;
    end
  end

  // Line-status latch: a new error in the same cycle as an LSR read survives.
  always_comb begin
    ls_pend_d = ls_pend_q;
    if (bus.oe | bus.pe | bus.fe | bus.bi) begin
      ls_pend_d = 1'b1;
    end else if (bus.lsr_rd) begin
      ls_pend_d = 1'b0;
    end
  end

  assign w_rda = bus.fifoen ? bus.rx_lvl_hit : bus.dr;

  // Pending flag tracks the next counter value so it rises with the final tick.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_pend_d = tmo_pend_q;
    if (!bus.fifoen || bus.rx_char || bus.rbr_rd || bus.rx_fifo_empty) begin
      tmo_cnt_d  = '0;
      tmo_pend_d = 1'b0;
    end else begin
      if (bus.char_tick && (tmo_cnt_q != C_TMO_MAX)) begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
      if (tmo_cnt_d == C_TMO_MAX) begin
        tmo_pend_d = 1'b1;
      end
    end
  end

  assign thre_d     = bus.thre;
  assign etbei_d    = bus.etbei;
  assign w_thre_set = (bus.thre & ~thre_q) | (bus.etbei & ~etbei_q & bus.thre);
  assign w_thre_clr = bus.thr_wr | (bus.iir_rd & (intid_q == C_ID_THR));

  always_comb begin
    thre_pend_d = thre_pend_q;
    if (w_thre_clr) begin
      thre_pend_d = 1'b0;
    end else if (w_thre_set) begin
      thre_pend_d = 1'b1;
    end
  end

  assign w_ls_en  = ls_pend_q   & bus.elsi;
  assign w_rda_en = w_rda       & bus.erbi;
  assign w_tmo_en = tmo_pend_q  & bus.erbi;
  assign w_thr_en = thre_pend_q & bus.etbei;

  always_comb begin
    intid_d   = C_ID_NONE;
    ipend_n_d = 1'b0;
    if (w_ls_en) begin
      intid_d = C_ID_LS;
    end else if (w_rda_en) begin
      intid_d = C_ID_RDA;
    end else if (w_tmo_en) begin
      intid_d = C_ID_TMO;
    end else if (w_thr_en) begin
      intid_d = C_ID_THR;
    end else begin
      ipend_n_d = 1'b1;
    end
  end

  assign bus.intid      = intid_q;
  assign bus.ipend_n    = ipend_n_q;
  assign bus.uart_intpt = ~ipend_n_q;

endmodule

`default_nettype wire
